sdram_pll_reset_ctrl: RTL
=========================

Name: sdram_pll_reset_ctrl

Overview:
Sequences the SDRAM PLL (50 MHz refclk in, two 200 MHz outputs, one phase-shifted -3000 ps). It drives the PLL reset, qualifies the asynchronous locked flag, and holds the SDRAM/system reset until lock has been continuously stable. It re-runs the PLL on lock timeout, on loss of lock, or on software request. It runs entirely on the free-running refclk, ahead of the PLL, so it never depends on PLL outputs.

Parameters:
RST_CYCLES, 16, refclk cycles pll_rst is held high per PLL reset pulse (>=1)
LOCK_TIMEOUT, 50000, refclk cycles to wait for lock before re-resetting the PLL (1 ms @ 50 MHz, >=1)
STABLE_CYCLES, 1024, refclk cycles locked must stay continuously high before release (>=1)
CNT_W, 8, width of saturating event counters

Ports:
refclk  in  1  50 MHz reference clock, same net as PLL refclk
rst  in  1  asynchronous active-high reset
pll_locked  in  1  PLL locked flag, asynchronous to refclk
pll_reset_req  in  1  synchronous request to restart the PLL sequence (level, sampled each cycle)
pll_rst  out  1  active-high reset to PLL rst pin
sys_rst  out  1  active-high reset to SDRAM controller/downstream logic
ready  out  1  high when PLL clocks are qualified (state RUN)
lock_lost  out  1  one-cycle pulse on loss of lock in RUN
relock_count  out  CNT_W  saturating count of lock losses in RUN
timeout_count  out  CNT_W  saturating count of lock timeouts
state_dbg  out  2  current state encoding (0 PLL_RESET, 1 WAIT_LOCK, 2 STABLE, 3 RUN)

Behaviour:
- Reset (rst=1, asynchronous): state=PLL_RESET, cnt=0, sync flops=0, pll_rst=1, sys_rst=1, ready=0, lock_lost=0, both counters=0, state_dbg=0.
- pll_locked passes through a 2-flop synchronizer, giving lock_s. lock_s lags pll_locked by 2 edges. No other path uses pll_locked.
- Outputs come only from registered state or registers. There is no combinational input-to-output path.
- pll_rst=1 only in PLL_RESET.
- sys_rst=1 in every state except RUN.
- ready = (state==RUN).
- Single counter cnt, width $clog2 of the largest of the three cycle parameters (+1). Cleared on every state change.
- Priority each cycle: pll_reset_req, then lock loss, then counter expiry.
- PLL_RESET: cnt increments. When cnt==RST_CYCLES-1, go to WAIT_LOCK, so pll_rst is high exactly RST_CYCLES cycles. pll_reset_req here restarts cnt at 0.
- WAIT_LOCK: pll_reset_req goes to PLL_RESET. Else lock_s=1 goes to STABLE. Else when cnt==LOCK_TIMEOUT-1, go to PLL_RESET and increment timeout_count. Else cnt++.
- STABLE: pll_reset_req goes to PLL_RESET. Else lock_s=0 goes to WAIT_LOCK (no PLL reset, no count). Else when cnt==STABLE_CYCLES-1, go to RUN. Else cnt++.
- RUN: pll_reset_req goes to PLL_RESET with no counter change. Else lock_s=0 goes to PLL_RESET, sets lock_lost=1 for exactly one cycle, and increments relock_count. sys_rst rises on the same edge ready falls.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Latency: locked first sampled at edge k gives ready=1 and sys_rst=0 after edge k+2+STABLE_CYCLES.
- rst mid-sequence aborts immediately to the reset values, including the counters.
- Downstream logic synchronizes sys_rst deassertion into the 200 MHz domain. That is not done here.

Test Plan:
(Bench params: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, CNT_W=4.)
- Power-up: release rst, raise pll_locked 2 cycles after pll_rst falls. Required: pll_rst high exactly 4 cycles, ready and sys_rst=0 exactly 10 edges after locked's first sampling edge, counters=0.
- Timeout: hold pll_locked=0. Required: pll_rst re-pulses every 24 cycles (4 reset + 20 wait). timeout_count increments once per pulse and saturates at 15 after 15 timeouts.
- Glitch during STABLE: locked high 5 cycles, then low 1 cycle, then high. Required: returns to WAIT_LOCK without a pll_rst pulse. ready rises 10 edges after the re-high is sampled. relock_count=0.
- Loss in RUN: drop pll_locked while ready=1. Required: 2 edges later ready=0, sys_rst=1, pll_rst=1, lock_lost pulses 1 cycle, relock_count=1, and a full re-sequence follows.
- Software request: assert pll_reset_req 1 cycle in RUN, then again in PLL_RESET at cnt=2. Required: enter PLL_RESET, restart cnt, pll_rst high 4 cycles after the second request, both counters unchanged.
- Async reset mid-STABLE: assert rst between edges. Required: pll_rst=1, sys_rst=1, state_dbg=0 immediately without waiting for a clock edge, and counters cleared.

Source files
------------

// File: rtl/sdram_pll_reset_ctrl.sv
// SDRAM PLL reset sequencer running on the free-running 50 MHz refclk.
// Ports: refclk, rst (async, active high), pll_locked (async), pll_reset_req;
//   outputs pll_rst, sys_rst, ready, lock_lost, relock_count, timeout_count,
//   state_dbg (0 PLL_RESET, 1 WAIT_LOCK, 2 STABLE, 3 RUN).
module sdram_pll_reset_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             pll_reset_req,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic             lock_lost,
  output logic [CNT_W-1:0] relock_count,
  output logic [CNT_W-1:0] timeout_count,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] S_PLL_RESET = 2'd0;
  localparam logic [1:0] S_WAIT_LOCK = 2'd1;
  localparam logic [1:0] S_STABLE    = 2'd2;
  localparam logic [1:0] S_RUN       = 2'd3;

  localparam int MAX_AB =
    (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_C =
    (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CW = $clog2(MAX_C) + 1;

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] ST_LAST  = CW'(STABLE_CYCLES - 1);

  logic [1:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          sync1, lock_s;
  logic          lost_n, to_inc, rl_inc;

  // Two-flop synchronizer; lock_s is the only consumer of pll_locked.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= pll_locked;
      lock_s <= sync1;
    end
  end

  // Priority: software request, then lock loss, then counter expiry.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    lost_n  = 1'b0;
    to_inc  = 1'b0;
    rl_inc  = 1'b0;
    unique case (state)
      S_PLL_RESET: begin
        if (pll_reset_req) begin
          cnt_n = '0;
        end else if (cnt == RST_LAST) begin
          state_n = S_WAIT_LOCK;
          cnt_n   = '0;
        end
      end
      S_WAIT_LOCK: begin
        if (pll_reset_req) begin
          state_n = S_PLL_RESET;
          cnt_n   = '0;
        end else if (lock_s) begin
          state_n = S_STABLE;
          cnt_n   = '0;
        end else if (cnt == TO_LAST) begin
          state_n = S_PLL_RESET;
          cnt_n   = '0;
          to_inc  = 1'b1;
        end
      end
      S_STABLE: begin
        if (pll_reset_req) begin
          state_n = S_PLL_RESET;
          cnt_n   = '0;
        end else if (!lock_s) begin
          state_n = S_WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt == ST_LAST) begin
          state_n = S_RUN;
          cnt_n   = '0;
        end
      end
      default: begin
        // RUN: counter is idle and held at zero.
        cnt_n = '0;
        if (pll_reset_req) begin
          state_n = S_PLL_RESET;
        end else if (!lock_s) begin
          state_n = S_PLL_RESET;
          lost_n  = 1'b1;
          rl_inc  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state         <= S_PLL_RESET;
      cnt           <= '0;
      lock_lost     <= 1'b0;
      relock_count  <= '0;
      timeout_count <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      lock_lost <= lost_n;
      if (rl_inc && relock_count != '1)
        relock_count <= relock_count + CNT_W'(1);
      if (to_inc && timeout_count != '1)
        timeout_count <= timeout_count + CNT_W'(1);
    end
  end

  // Pure decodes of the state register.
  assign pll_rst   = (state == S_PLL_RESET);
  assign sys_rst   = (state != S_RUN);
  assign ready     = (state == S_RUN);
  assign state_dbg = state;

endmodule
